// File: rtl/atoi_stream.sv
// rtl/atoi_stream.sv - ASCII decimal character stream to binary integer converter
// One char per clock, no backpressure; each delimiter-terminated number yields a one-cycle result pulse.
module atoi_stream #(
  parameter int OUT_W      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int SIGNED     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_num,
  output logic             out_err,
  output logic [3:0]       out_ndig,
  output logic             busy
);

  // Four spare bits above OUT_W keep acc*10+9 exact for any acc up to LIMIT.
  localparam int AW = OUT_W + 4;
  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] LIM_UNS   = (ONE << OUT_W) - ONE;
  localparam logic [AW-1:0] LIM_POS   = (ONE << (OUT_W - 1)) - ONE;
  localparam logic [AW-1:0] LIM_NEG   = ONE << (OUT_W - 1);
  localparam logic [3:0]    MAX_NDIG  = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SIGN,
    S_ACCUM,
    S_ERR
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    acc_q;
  logic [3:0]       ndig_q;
  logic             neg_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_num_q;
  logic             out_err_q;
  logic [3:0]       out_ndig_q;

  logic             is_digit;
  logic             is_delim;
  logic             is_minus;
  logic [AW-1:0]    digit_val;
  logic [AW-1:0]    acc_d;
  logic [3:0]       ndig_d;
  logic [AW-1:0]    limit;
  logic             over;
  logic [OUT_W-1:0] good_num_d;

  always_comb begin
    is_digit   = (in_char >= 8'h30) && (in_char <= 8'h39);
    is_delim   = (in_char == 8'h20) || (in_char == 8'h2C) || (in_char == 8'h09) ||
                 (in_char == 8'h0D) || (in_char == 8'h0A);
    is_minus   = (in_char == 8'h2D);
    digit_val  = AW'(in_char[3:0]);
    acc_d      = (acc_q << 3) + (acc_q << 1) + digit_val;
    ndig_d     = (ndig_q == 4'd15) ? 4'd15 : ndig_q + 4'd1;
    if (SIGNED == 0) begin
      limit = LIM_UNS;
    end else if (neg_q) begin
      limit = LIM_NEG;
    end else begin
      limit = LIM_POS;
    end
    over       = (ndig_q >= MAX_NDIG) || (acc_d > limit);
    good_num_d = neg_q ? (~acc_q[OUT_W-1:0] + 1'b1) : acc_q[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ndig_q      <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_err_q   <= 1'b0;
      out_ndig_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          S_IDLE: begin
            if (is_digit) begin
              state_q <= S_ACCUM;
              acc_q   <= digit_val;
              ndig_q  <= 4'd1;
              neg_q   <= 1'b0;
            end else if (is_delim) begin
              state_q <= S_IDLE;
            end else if (is_minus && (SIGNED != 0)) begin
              state_q <= S_SIGN;
              acc_q   <= '0;
              ndig_q  <= '0;
              neg_q   <= 1'b1;
            end else begin
              state_q <= S_ERR;
              acc_q   <= '0;
              ndig_q  <= '0;
              neg_q   <= 1'b0;
            end
          end
          S_SIGN: begin
            if (is_digit) begin
              state_q <= S_ACCUM;
              acc_q   <= digit_val;
              ndig_q  <= 4'd1;
            end else if (is_delim) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b1;
              out_num_q   <= '0;
              out_err_q   <= 1'b1;
              out_ndig_q  <= ndig_q;
            end else begin
              state_q <= S_ERR;
            end
          end
          S_ACCUM: begin
            if (is_digit) begin
              ndig_q <= ndig_d;
              if (over) begin
                state_q <= S_ERR;
              end else begin
                acc_q <= acc_d;
              end
            end else if (is_delim) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b1;
              out_num_q   <= good_num_d;
              out_err_q   <= 1'b0;
              out_ndig_q  <= ndig_q;
            end else begin
              state_q <= S_ERR;
            end
          end
          S_ERR: begin
            // Digits are still counted so the error result reports how many were seen.
            if (is_digit) begin
              ndig_q <= ndig_d;
            end else if (is_delim) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b1;
              out_num_q   <= '0;
              out_err_q   <= 1'b1;
              out_ndig_q  <= ndig_q;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_err   = out_err_q;
  assign out_ndig  = out_ndig_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_atoi_stream.sv
// tb/tb_atoi_stream.sv - scoreboard bench for atoi_stream (default and signed 8-bit instances)
module tb_atoi_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_valid, s_valid;
  logic [7:0]  a_char, s_char;
  logic        a_out_valid, s_out_valid;
  logic [15:0] a_num;
  logic [7:0]  s_num;
  logic        a_err, s_err;
  logic [3:0]  a_ndig, s_ndig;
  logic        a_busy, s_busy;

  atoi_stream u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_char(a_char),
    .out_valid(a_out_valid), .out_num(a_num), .out_err(a_err),
    .out_ndig(a_ndig), .busy(a_busy)
  );

  atoi_stream #(.OUT_W(8), .MAX_DIGITS(3), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_char(s_char),
    .out_valid(s_out_valid), .out_num(s_num), .out_err(s_err),
    .out_ndig(s_ndig), .busy(s_busy)
  );

  typedef struct {
    logic [15:0] num;
    logic        err;
    logic [3:0]  ndig;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_s[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_out_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_pulse: got num=0x%0h err=%0d expected no pulse", a_num, a_err);
      end else begin
        e = q_a.pop_front();
        chk("a_num", 32'(a_num), 32'(e.num));
        chk("a_err", 32'(a_err), 32'(e.err));
        chk("a_ndig", 32'(a_ndig), 32'(e.ndig));
        chk("a_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_s
    exp_t e;
    if (s_out_valid === 1'b1) begin
      if (q_s.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s_unexpected_pulse: got num=0x%0h err=%0d expected no pulse", s_num, s_err);
      end else begin
        e = q_s.pop_front();
        chk("s_num", 32'(s_num), 32'(e.num));
        chk("s_err", 32'(s_err), 32'(e.err));
        chk("s_ndig", 32'(s_ndig), 32'(e.ndig));
        chk("s_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] c);
    if (sel) begin
      s_valid = 1'b1;
      s_char  = c;
    end else begin
      a_valid = 1'b1;
      a_char  = c;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic send_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) send(sel, s[i]);
  endtask

  // The final char of s is the terminator; its result is due the cycle after it is accepted.
  task automatic send_num(input bit sel, input string s, input logic [15:0] num,
                          input bit err, input logic [3:0] ndig);
    exp_t e;
    send_str(sel, s);
    e.num  = num;
    e.err  = err;
    e.ndig = ndig;
    e.cyc  = cyc;
    if (sel) q_s.push_back(e);
    else     q_a.push_back(e);
  endtask

  initial begin
    reset   = 1'b1;
    a_valid = 1'b0;
    s_valid = 1'b0;
    a_char  = 8'h00;
    s_char  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_a_valid", 32'(a_out_valid), 0);
    chk("reset_a_num", 32'(a_num), 0);
    chk("reset_a_err", 32'(a_err), 0);
    chk("reset_a_ndig", 32'(a_ndig), 0);
    chk("reset_a_busy", 32'(a_busy), 0);
    chk("reset_s_valid", 32'(s_out_valid), 0);
    chk("reset_s_busy", 32'(s_busy), 0);

    send_num(0, "65535 ", 16'hFFFF, 0, 4'd5);
    send_num(0, "65536,", 16'h0000, 1, 4'd5);
    send_num(0, "000123 ", 16'h0000, 1, 4'd6);
    send_num(0, "12,", 16'h000C, 0, 4'd2);
    send_num(0, "34\015", 16'h0022, 0, 4'd2);
    send_num(0, "12a4 ", 16'h0000, 1, 4'd3);
    send_num(0, "7 ", 16'h0007, 0, 4'd1);
    send_num(0, "0\t", 16'h0000, 0, 4'd1);
    send_num(0, "-5\012", 16'h0000, 1, 4'd1);
    send_num(0, "12345678901234567 ", 16'h0000, 1, 4'd15);
    send_str(0, "  ");

    send_str(0, "1");
    @(negedge clk);
    chk("a_busy_mid_number", 32'(a_busy), 1);
    send_num(0, " ", 16'h0001, 0, 4'd1);

    send_str(0, "12");
    reset   = 1'b1;
    a_valid = 1'b1;
    a_char  = "5";
    @(posedge clk);
    #1;
    reset   = 1'b0;
    a_valid = 1'b0;
    @(negedge clk);
    chk("a_busy_after_reset", 32'(a_busy), 0);
    send_num(0, "3 ", 16'h0003, 0, 4'd1);

    send_num(1, "-128 ", 16'h0080, 0, 4'd3);
    send_num(1, "127 ", 16'h007F, 0, 4'd3);
    send_num(1, "128 ", 16'h0000, 1, 4'd3);
    send_num(1, "- ", 16'h0000, 1, 4'd0);
    send_num(1, "-0 ", 16'h0000, 0, 4'd1);
    send_num(1, "-129,", 16'h0000, 1, 4'd3);
    send_num(1, "--1 ", 16'h0000, 1, 4'd1);
    send_num(1, "-1000 ", 16'h0000, 1, 4'd4);
    send_num(1, "-7 ", 16'h00F9, 0, 4'd1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("a_queue_drained", q_a.size(), 0);
    chk("s_queue_drained", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
